// File: rtl/iob_plic_irq_ctrl.sv
// iob_plic_irq_ctrl: IOb master that configures one PLIC target and then runs
// the claim / dispatch / complete loop in hardware.
module iob_plic_irq_ctrl #(
  parameter int                ADDR_W    = 16,
  parameter int                DATA_W    = 32,
  parameter int                SOURCES   = 8,
  parameter logic [ADDR_W-1:0] PRIO_ADDR = 16'h0000,
  parameter logic [ADDR_W-1:0] EN_ADDR   = 16'h0040,
  parameter logic [ADDR_W-1:0] TH_ADDR   = 16'h0080,
  parameter logic [ADDR_W-1:0] ID_ADDR   = 16'h0084,
  parameter logic [DATA_W-1:0] INIT_PRIO = 32'd1,
  parameter logic [DATA_W-1:0] INIT_TH   = 32'd0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [SOURCES-1:0]           en_mask,
  input  logic                         reconfig,
  input  logic                         irq,
  output logic                         m_valid,
  output logic [ADDR_W-1:0]            m_address,
  output logic [DATA_W-1:0]            m_wdata,
  output logic [DATA_W/8-1:0]          m_wstrb,
  input  logic [DATA_W-1:0]            m_rdata,
  input  logic                         m_ready,
  output logic                         id_valid,
  output logic [$clog2(SOURCES+1)-1:0] id,
  input  logic                         id_ready,
  input  logic                         done,
  output logic                         cfg_done,
  output logic                         spurious
);

  // state     | meaning
  // CFG_PRIO  | writing priority of source cnt
  // CFG_EN    | writing target enable mask
  // CFG_TH    | writing target threshold
  // WAIT_IRQ  | idle, waiting for irq or a pending reconfig
  // CLAIM     | reading the claim register
  // DISPATCH  | offering the claimed id to the consumer
  // WAIT_DONE | consumer is servicing the id
  // COMPLETE  | writing the id back as completion
  typedef enum logic [2:0] {
    CFG_PRIO, CFG_EN, CFG_TH, WAIT_IRQ, CLAIM, DISPATCH, WAIT_DONE, COMPLETE
  } state_t;

  localparam int ID_W = $clog2(SOURCES+1);
  localparam logic [DATA_W/8-1:0] STRB_WR = '1;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   cnt;
  logic              reconfig_pend;
  logic              reconfig_seen;
  logic              xfer;
  logic [ID_W-1:0]   rid;
  logic              rid_bad;
  logic [ADDR_W-1:0] prio_off;
  logic              unused_rdata;

  assign xfer          = m_valid && m_ready;
  assign reconfig_seen = reconfig_pend || reconfig;
  assign rid           = m_rdata[ID_W-1:0];
  assign rid_bad       = (rid == '0) || (rid > ID_W'(SOURCES));
  assign prio_off      = ADDR_W'(cnt - ID_W'(1)) << 2;
  // only the low id bits of the claim word carry information
  assign unused_rdata  = ^m_rdata[DATA_W-1:ID_W];

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= CFG_PRIO;
    else     state <= state_nxt;
  end

  // next-state decode; bus states advance only on a completed transfer
  always_comb begin
    state_nxt = state;
    case (state)
      CFG_PRIO:  if (xfer && cnt == ID_W'(SOURCES)) state_nxt = CFG_EN;
      CFG_EN:    if (xfer) state_nxt = CFG_TH;
      CFG_TH:    if (xfer) state_nxt = WAIT_IRQ;
      WAIT_IRQ: begin
        if (reconfig_seen) state_nxt = CFG_PRIO;
        else if (irq)      state_nxt = CLAIM;
      end
      CLAIM:     if (xfer) state_nxt = rid_bad ? WAIT_IRQ : DISPATCH;
      DISPATCH:  if (id_ready) state_nxt = WAIT_DONE;
      WAIT_DONE: if (done) state_nxt = COMPLETE;
      COMPLETE:  if (xfer) state_nxt = WAIT_IRQ;
      default:   state_nxt = CFG_PRIO;
    endcase
  end

  // bus request registers, counters and consumer handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid       <= 1'b0;
      m_address     <= '0;
      m_wdata       <= '0;
      m_wstrb       <= '0;
      cnt           <= ID_W'(1);
      reconfig_pend <= 1'b0;
      id_valid      <= 1'b0;
      id            <= '0;
      cfg_done      <= 1'b0;
      spurious      <= 1'b0;
    end else begin
      spurious <= 1'b0;
      if (reconfig) reconfig_pend <= 1'b1;
      // a finished transfer always leaves one idle cycle before the next one
      if (xfer) m_valid <= 1'b0;
      case (state)
        CFG_PRIO: begin
          if (!m_valid) begin
            m_valid   <= 1'b1;
            m_address <= PRIO_ADDR + prio_off;
            m_wdata   <= INIT_PRIO;
            m_wstrb   <= STRB_WR;
          end
          if (xfer && cnt != ID_W'(SOURCES)) cnt <= cnt + ID_W'(1);
        end
        CFG_EN: begin
          if (!m_valid) begin
            m_valid   <= 1'b1;
            m_address <= EN_ADDR;
            m_wdata   <= DATA_W'(en_mask);
            m_wstrb   <= STRB_WR;
          end
        end
        CFG_TH: begin
          if (!m_valid) begin
            m_valid   <= 1'b1;
            m_address <= TH_ADDR;
            m_wdata   <= INIT_TH;
            m_wstrb   <= STRB_WR;
          end
          if (xfer) cfg_done <= 1'b1;
        end
        WAIT_IRQ: begin
          if (reconfig_seen) begin
            cfg_done      <= 1'b0;
            cnt           <= ID_W'(1);
            reconfig_pend <= 1'b0;
          end
        end
        CLAIM: begin
          if (!m_valid) begin
            m_valid   <= 1'b1;
            m_address <= ID_ADDR;
            m_wdata   <= '0;
            m_wstrb   <= '0;
          end
          if (xfer) begin
            if (rid_bad) begin
              spurious <= 1'b1;
            end else begin
              id       <= rid;
              id_valid <= 1'b1;
            end
          end
        end
        DISPATCH: if (id_ready) id_valid <= 1'b0;
        COMPLETE: begin
          if (!m_valid) begin
            m_valid   <= 1'b1;
            m_address <= ID_ADDR;
            m_wdata   <= DATA_W'(id);
            m_wstrb   <= STRB_WR;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iob_plic_irq_ctrl.sv
// Bench for iob_plic_irq_ctrl: wait-state IOb slave, small PLIC model,
// bus-transaction scoreboard and a table of claim scenarios.
module tb_iob_plic_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  en_mask = 8'h00;
  logic        reconfig = 1'b0;
  logic        irq;
  logic        m_valid;
  logic [15:0] m_address;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic [31:0] m_rdata;
  logic        m_ready;
  logic        id_valid;
  logic [3:0]  id;
  logic        id_ready = 1'b0;
  logic        done = 1'b0;
  logic        cfg_done;
  logic        spurious;

  iob_plic_irq_ctrl dut (
    .clk(clk), .rst(rst), .en_mask(en_mask), .reconfig(reconfig), .irq(irq),
    .m_valid(m_valid), .m_address(m_address), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_rdata(m_rdata), .m_ready(m_ready), .id_valid(id_valid), .id(id),
    .id_ready(id_ready), .done(done), .cfg_done(cfg_done), .spurious(spurious)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } bus_t;

  typedef struct {
    logic [31:0] claim;
    int          dly;
    logic        spur;
    logic [3:0]  id;
  } vec_t;

  bus_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  // ---------------- slave with programmable wait states ----------------
  int          ws_cfg = 0;
  int          wcnt;
  logic [31:0] claim_data = 32'h0;
  logic        plic_mode = 1'b0;
  logic        irq_drv = 1'b0;
  logic [7:0]  plic_src = 8'h00;

  assign m_ready = m_valid && (wcnt >= ws_cfg);

  always @(posedge clk or posedge rst) begin
    if (rst)                     wcnt <= 0;
    else if (m_valid && !m_ready) wcnt <= wcnt + 1;
    else                         wcnt <= 0;
  end

  // ---------------- PLIC model (one target) ----------------
  logic [8:1]  pend, insvc, en_r;
  logic [31:0] prio_r [1:8];
  logic [31:0] th_r;
  logic [3:0]  best;
  logic [31:0] bp;

  always_comb begin
    best = 4'd0;
    bp   = th_r;
    for (int i = 1; i <= 8; i++)
      if (pend[i] && en_r[i] && prio_r[i] > bp) begin
        best = 4'(i);
        bp   = prio_r[i];
      end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend  <= '0;
      insvc <= '0;
      en_r  <= '0;
      th_r  <= '0;
      for (int i = 1; i <= 8; i++) prio_r[i] <= '0;
    end else begin
      for (int i = 1; i <= 8; i++)
        if (plic_src[i-1] && !insvc[i]) pend[i] <= 1'b1;
      if (plic_mode && m_valid && m_ready) begin
        if (m_wstrb != 4'h0) begin
          if (m_address < 16'h0020) prio_r[int'(m_address[4:2]) + 1] <= m_wdata;
          else if (m_address == 16'h0040) en_r <= m_wdata[7:0];
          else if (m_address == 16'h0080) th_r <= m_wdata;
          else if (m_address == 16'h0084 && m_wdata >= 32'd1 && m_wdata <= 32'd8)
            insvc[m_wdata[3:0]] <= 1'b0;
        end else if (m_address == 16'h0084 && best != 4'd0) begin
          pend[best]  <= 1'b0;
          insvc[best] <= 1'b1;
        end
      end
    end
  end

  assign irq     = plic_mode ? (best != 4'd0) : irq_drv;
  assign m_rdata = plic_mode ? {28'h0, best} : claim_data;

  // ---------------- bus monitor / scoreboard ----------------
  logic hold_prev = 1'b0;
  logic xfer_prev = 1'b0;
  bus_t held;
  bus_t e;
  int   xfer_cnt = 0;
  int   spur_cnt = 0;
  logic idv_seen = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
      xfer_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", 64'(m_valid), 64'(1));
        check("hold_addr", 64'(m_address), 64'(held.addr));
        check("hold_wdata", 64'(m_wdata), 64'(held.data));
        check("hold_wstrb", 64'(m_wstrb), 64'(held.strb));
      end
      if (xfer_prev) check("gap_valid_low", 64'(m_valid), 64'(0));
      if (m_valid && m_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL bus_unexpected: got addr %0h wdata %0h wstrb %0h, expected no transfer",
                   m_address, m_wdata, m_wstrb);
        end else begin
          e = exp_q.pop_front();
          check("bus_addr", 64'(m_address), 64'(e.addr));
          check("bus_wstrb", 64'(m_wstrb), 64'(e.strb));
          if (e.strb != 4'h0) check("bus_wdata", 64'(m_wdata), 64'(e.data));
        end
      end
      hold_prev = m_valid && !m_ready;
      xfer_prev = m_valid && m_ready;
      held      = '{m_address, m_wdata, m_wstrb};
      if (spurious) spur_cnt++;
      if (id_valid) idv_seen = 1'b1;
    end
  end

  // ---------------- helpers ----------------
  task automatic push_w(input logic [15:0] a, input logic [31:0] d);
    exp_q.push_back('{a, d, 4'hF});
  endtask

  task automatic push_r(input logic [15:0] a);
    exp_q.push_back('{a, 32'h0, 4'h0});
  endtask

  task automatic push_cfg(input logic [7:0] mask);
    for (int i = 0; i < 8; i++) push_w(16'(4 * i), 32'd1);
    push_w(16'h0040, {24'h0, mask});
    push_w(16'h0080, 32'd0);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_q_empty(input string name);
    for (int t = 0; t < 80 && (exp_q.size() != 0 || m_valid); t++) @(negedge clk);
    check(name, 64'(exp_q.size()), 64'(0));
  endtask

  task automatic do_reset_cfg(input int ws, input logic [7:0] mask);
    rst = 1'b1;
    ws_cfg = ws;
    en_mask = mask;
    irq_drv = 1'b0;
    id_ready = 1'b0;
    done = 1'b0;
    reconfig = 1'b0;
    exp_q.delete();
    cycles(2);
    check("rst_ctrl", 64'({m_valid, id_valid, cfg_done, spurious}), 64'(0));
    check("rst_bus", 64'({m_address, m_wdata, m_wstrb}), 64'(0));
    check("rst_id", 64'(id), 64'(0));
    push_cfg(mask);
    xfer_cnt = 0;
    rst = 1'b0;
    for (int t = 0; t < 400 && !cfg_done; t++) @(negedge clk);
    check("cfg_done_set", 64'(cfg_done), 64'(1));
    check("cfg_after_10_xfers", 64'(xfer_cnt), 64'(10));
    check("cfg_q_empty", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic run_claim(input vec_t v);
    int t;
    int spur0;
    spur0 = spur_cnt;
    idv_seen = 1'b0;
    push_r(16'h0084);
    claim_data = v.claim;
    irq_drv = 1'b1;
    if (!v.spur) begin
      t = 0;
      while (t < 60) begin
        @(negedge clk);
        t++;
        if (id_valid) break;
        if (m_valid && m_ready && m_wstrb == 4'h0) irq_drv = 1'b0;
      end
      irq_drv = 1'b0;
      check("id_valid_rise", 64'(id_valid), 64'(1));
      if (ws_cfg == 0) check("irq_to_id_valid", 64'(t), 64'(3));
      check("claim_id", 64'(id), 64'(v.id));
      repeat (v.dly) begin
        check("id_valid_hold", 64'(id_valid), 64'(1));
        check("id_hold", 64'(id), 64'(v.id));
        @(negedge clk);
      end
      id_ready = 1'b1;
      @(negedge clk);
      id_ready = 1'b0;
      check("id_valid_drop", 64'(id_valid), 64'(0));
      cycles(2);
      push_w(16'h0084, 32'(v.id));
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      wait_q_empty("complete_written");
    end else begin
      for (int k = 0; k < 60; k++) begin
        @(negedge clk);
        if (m_valid && m_ready && m_wstrb == 4'h0) break;
      end
      irq_drv = 1'b0;
      cycles(3);
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      cycles(4);
      check("spurious_pulses", 64'(spur_cnt - spur0), 64'(1));
      check("spurious_no_id_valid", 64'(idv_seen), 64'(0));
      check("spurious_q_empty", 64'(exp_q.size()), 64'(0));
    end
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{32'd5,          4, 1'b0, 4'd5};
    vecs[1] = '{32'd0,          0, 1'b1, 4'd0};
    vecs[2] = '{32'd12,         0, 1'b1, 4'd0};
    vecs[3] = '{32'd8,          1, 1'b0, 4'd8};
    vecs[4] = '{32'hFFFF_FFF3,  0, 1'b0, 4'd3};
    vecs[5] = '{32'd1,          2, 1'b0, 4'd1};

    // zero-wait slave: configuration then the claim table
    do_reset_cfg(0, 8'hA5);
    for (int i = 0; i < 6; i++) run_claim(vecs[i]);

    // three wait states: held request, idle gap, claim paths
    do_reset_cfg(3, 8'h5A);
    run_claim(vecs[0]);
    run_claim(vecs[2]);

    // reset in the middle of a transfer with a reconfig pending
    push_cfg(8'h5A);
    reconfig = 1'b1;
    @(negedge clk);
    reconfig = 1'b0;
    for (int t = 0; t < 40 && !m_valid; t++) @(negedge clk);
    reconfig = 1'b1;
    @(negedge clk);
    reconfig = 1'b0;
    #2 rst = 1'b1;
    #1 check("rst_async_valid", 64'(m_valid), 64'(0));
    do_reset_cfg(0, 8'h3C);
    cycles(20);
    check("pending_reconfig_cleared", 64'(xfer_cnt), 64'(10));

    // reconfig during DISPATCH: service completes, then config reruns
    push_r(16'h0084);
    claim_data = 32'd3;
    irq_drv = 1'b1;
    for (int t = 0; t < 60 && !id_valid; t++) begin
      @(negedge clk);
      if (m_valid && m_ready) irq_drv = 1'b0;
    end
    irq_drv = 1'b0;
    check("rc_id", 64'(id), 64'(3));
    reconfig = 1'b1;
    @(negedge clk);
    reconfig = 1'b0;
    en_mask = 8'hC3;
    cycles(2);
    check("rc_dispatch_holds", 64'(id_valid), 64'(1));
    check("rc_cfg_done_still", 64'(cfg_done), 64'(1));
    id_ready = 1'b1;
    @(negedge clk);
    id_ready = 1'b0;
    cycles(1);
    push_w(16'h0084, 32'd3);
    push_cfg(8'hC3);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    for (int t = 0; t < 60 && cfg_done; t++) @(negedge clk);
    check("rc_cfg_done_cleared", 64'(cfg_done), 64'(0));
    check("rc_completion_first", 64'(exp_q.size()), 64'(10));
    for (int t = 0; t < 200 && !cfg_done; t++) @(negedge clk);
    check("rc_cfg_done_again", 64'(cfg_done), 64'(1));
    check("rc_q_empty", 64'(exp_q.size()), 64'(0));

    // against the PLIC model: sources 3 and 7 at equal priority
    plic_mode = 1'b1;
    do_reset_cfg(0, 8'hFF);
    push_r(16'h0084);
    push_w(16'h0084, 32'd3);
    push_r(16'h0084);
    push_w(16'h0084, 32'd7);
    plic_src = 8'b0100_0100;
    @(negedge clk);
    plic_src = 8'h00;
    for (int k = 0; k < 2; k++) begin
      for (int t = 0; t < 60; t++) begin
        @(negedge clk);
        if (id_valid) break;
      end
      check("plic_id", 64'(id), (k == 0) ? 64'(3) : 64'(7));
      id_ready = 1'b1;
      @(negedge clk);
      id_ready = 1'b0;
      cycles(1);
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
    end
    wait_q_empty("plic_q_empty");
    cycles(2);
    check("plic_irq_low", 64'(irq), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
